// File: rtl/comparator_pkg.sv
// comparator_pkg: shared result encoding, slice width, stats counter width
// and the saturating-increment helper used by the optional stats counters.
package comparator_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_LT = 2'b01,
        CMP_GT = 2'b10
    } cmp_res_t;

    localparam int STATS_W = 16;
    localparam int SLICE_W = 4;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// comparator_slice: combinational 4-bit unsigned compare, MSB-first; the
// highest differing bit decides, eq only when all four bits match.
module comparator_slice
    import comparator_pkg::*;
(
    input  logic [SLICE_W-1:0] i_w_a,
    input  logic [SLICE_W-1:0] i_w_b,
    output logic               o_w_lt,
    output logic               o_w_gt,
    output logic               o_w_eq
);

    // Scan from the MSB down; the first mismatch fixes the relation.
    always_comb begin
        logic w_done;
        o_w_lt = 1'b0;
        o_w_gt = 1'b0;
        w_done = 1'b0;
        for (int i = SLICE_W-1; i >= 0; i--) begin
            if (!w_done && (i_w_a[i] != i_w_b[i])) begin
                o_w_lt = i_w_b[i];
                o_w_gt = i_w_a[i];
                w_done = 1'b1;
            end
        end
        o_w_eq = !w_done;
    end

endmodule

// File: rtl/comparator.sv
// comparator: registered WIDTH-bit magnitude compare (unsigned or two's
// complement), one cycle latency. Optional stats counters are enabled by
// defining COMPARATOR_STATS_EN.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter bit SIGNED_DEFAULT = 1'b0
) (
    input  logic               i_w_clk,
    input  logic               i_w_rst_n,
    input  logic               i_w_valid,
    input  logic               i_w_signed,
    input  logic [WIDTH-1:0]   i_w_a,
    input  logic [WIDTH-1:0]   i_w_b,
`ifdef COMPARATOR_STATS_EN
    input  logic               i_w_stats_clr,
    output logic [STATS_W-1:0] o_w_cnt_lt,
    output logic [STATS_W-1:0] o_w_cnt_gt,
    output logic [STATS_W-1:0] o_w_cnt_eq,
`endif
    output logic               o_w_valid,
    output logic               o_w_lt,
    output logic               o_w_gt,
    output logic               o_w_eq
);

    localparam int NSL = (WIDTH + SLICE_W - 1) / SLICE_W;
    localparam int PW  = NSL * SLICE_W;

    // SIGNED_DEFAULT only documents the integrator's tie-off value.
    logic w_unused_signed_default;
    assign w_unused_signed_default = SIGNED_DEFAULT;

    // Flipping the sign bit of both operands maps two's complement order
    // onto unsigned order, so one unsigned chain serves both modes.
    logic [WIDTH-1:0] w_flip, w_a_adj, w_b_adj;
    assign w_flip  = WIDTH'(i_w_signed) << (WIDTH - 1);
    assign w_a_adj = i_w_a ^ w_flip;
    assign w_b_adj = i_w_b ^ w_flip;

    // Zero padding above the MSB matches on both sides and never decides.
    logic [NSL-1:0][SLICE_W-1:0] w_pa, w_pb;
    assign w_pa = PW'(w_a_adj);
    assign w_pb = PW'(w_b_adj);

    logic [NSL-1:0] w_s_lt, w_s_gt, w_s_eq;
    logic [NSL:0]   w_c_lt, w_c_gt, w_c_eq;

    assign w_c_lt[NSL] = 1'b0;
    assign w_c_gt[NSL] = 1'b0;
    assign w_c_eq[NSL] = 1'b1;

    // Slice chain: a lower slice only decides while everything above matched.
    for (genvar k = 0; k < NSL; k++) begin : g_slice
        comparator_slice u_slice (
            .i_w_a  (w_pa[k]),
            .i_w_b  (w_pb[k]),
            .o_w_lt (w_s_lt[k]),
            .o_w_gt (w_s_gt[k]),
            .o_w_eq (w_s_eq[k])
        );
        assign w_c_lt[k] = w_c_lt[k+1] | (w_c_eq[k+1] & w_s_lt[k]);
        assign w_c_gt[k] = w_c_gt[k+1] | (w_c_eq[k+1] & w_s_gt[k]);
        assign w_c_eq[k] = w_c_eq[k+1] & w_s_eq[k];
    end

    // Encode the chain outcome as a single result class.
    cmp_res_t w_res;
    always_comb begin
        w_res = CMP_EQ;
        if (w_c_lt[0])      w_res = CMP_LT;
        else if (w_c_gt[0]) w_res = CMP_GT;
    end

    logic r_valid, r_lt, r_gt, r_eq;

    // Valid qualifier: follows the input valid with one cycle delay.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) r_valid <= 1'b0;
        else            r_valid <= i_w_valid;
    end

    // Result flags: load on valid, hold through idle cycles.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            r_lt <= 1'b0;
            r_gt <= 1'b0;
            r_eq <= 1'b0;
        end else if (i_w_valid) begin
            r_lt <= (w_res == CMP_LT);
            r_gt <= (w_res == CMP_GT);
            r_eq <= (w_res == CMP_EQ);
        end
    end

    assign o_w_valid = r_valid;
    assign o_w_lt    = r_lt;
    assign o_w_gt    = r_gt;
    assign o_w_eq    = r_eq;

`ifdef COMPARATOR_STATS_EN
    logic [STATS_W-1:0] r_cnt_lt, r_cnt_gt, r_cnt_eq;

    // Per-class saturating counters; clear wins over a same-edge increment.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            r_cnt_lt <= '0;
            r_cnt_gt <= '0;
            r_cnt_eq <= '0;
        end else if (i_w_stats_clr) begin
            r_cnt_lt <= '0;
            r_cnt_gt <= '0;
            r_cnt_eq <= '0;
        end else if (i_w_valid) begin
            case (w_res)
                CMP_LT:  r_cnt_lt <= sat_inc(r_cnt_lt);
                CMP_GT:  r_cnt_gt <= sat_inc(r_cnt_gt);
                default: r_cnt_eq <= sat_inc(r_cnt_eq);
            endcase
        end
    end

    assign o_w_cnt_lt = r_cnt_lt;
    assign o_w_cnt_gt = r_cnt_gt;
    assign o_w_cnt_eq = r_cnt_eq;
`endif

endmodule

// File: tb/tb_comparator.sv
// tb_comparator: random + directed checks of comparator at WIDTH=1, 8, 13
// against an arithmetic reference model; covers stats counters when
// COMPARATOR_STATS_EN is defined.
module tb_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        sgn = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [12:0] a13 = '0, b13 = '0;

    logic o1_v, o1_lt, o1_gt, o1_eq;
    logic o8_v, o8_lt, o8_gt, o8_eq;
    logic o13_v, o13_lt, o13_gt, o13_eq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef COMPARATOR_STATS_EN
    logic        clr = 1'b0;
    logic [15:0] c1_lt, c1_gt, c1_eq, c8_lt, c8_gt, c8_eq, c13_lt, c13_gt, c13_eq;
    logic [15:0] m_lt, m_gt, m_eq;
`endif

    comparator #(.WIDTH(1)) dut1 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(valid), .i_w_signed(sgn),
        .i_w_a(a1), .i_w_b(b1),
`ifdef COMPARATOR_STATS_EN
        .i_w_stats_clr(clr), .o_w_cnt_lt(c1_lt), .o_w_cnt_gt(c1_gt), .o_w_cnt_eq(c1_eq),
`endif
        .o_w_valid(o1_v), .o_w_lt(o1_lt), .o_w_gt(o1_gt), .o_w_eq(o1_eq));

    comparator #(.WIDTH(8)) dut8 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(valid), .i_w_signed(sgn),
        .i_w_a(a8), .i_w_b(b8),
`ifdef COMPARATOR_STATS_EN
        .i_w_stats_clr(clr), .o_w_cnt_lt(c8_lt), .o_w_cnt_gt(c8_gt), .o_w_cnt_eq(c8_eq),
`endif
        .o_w_valid(o8_v), .o_w_lt(o8_lt), .o_w_gt(o8_gt), .o_w_eq(o8_eq));

    comparator #(.WIDTH(13)) dut13 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_valid(valid), .i_w_signed(sgn),
        .i_w_a(a13), .i_w_b(b13),
`ifdef COMPARATOR_STATS_EN
        .i_w_stats_clr(clr), .o_w_cnt_lt(c13_lt), .o_w_cnt_gt(c13_gt), .o_w_cnt_eq(c13_eq),
`endif
        .o_w_valid(o13_v), .o_w_lt(o13_lt), .o_w_gt(o13_gt), .o_w_eq(o13_eq));

    // Reference relation {lt,gt,eq} from plain integer comparison.
    function automatic logic [2:0] ref_rel(input logic [63:0] a, input logic [63:0] b,
                                           input int w, input bit s);
        longint sa, sb;
        if (s) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            return (sa < sb) ? 3'b100 : (sa > sb) ? 3'b010 : 3'b001;
        end
        return (a < b) ? 3'b100 : (a > b) ? 3'b010 : 3'b001;
    endfunction

    // Expected {valid,lt,gt,eq} per instance.
    logic [3:0] m1, m8, m13;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= '0; m8 <= '0; m13 <= '0;
        end else if (valid) begin
            m1  <= {1'b1, ref_rel(64'(a1),  64'(b1),  1,  sgn)};
            m8  <= {1'b1, ref_rel(64'(a8),  64'(b8),  8,  sgn)};
            m13 <= {1'b1, ref_rel(64'(a13), 64'(b13), 13, sgn)};
        end else begin
            m1[3] <= 1'b0; m8[3] <= 1'b0; m13[3] <= 1'b0;
        end
    end

`ifdef COMPARATOR_STATS_EN
    // Expected counters for the 8-bit instance.
    always @(posedge clk or negedge rst_n) begin
        logic [2:0] r;
        if (!rst_n) begin
            m_lt <= '0; m_gt <= '0; m_eq <= '0;
        end else if (clr) begin
            m_lt <= '0; m_gt <= '0; m_eq <= '0;
        end else if (valid) begin
            r = ref_rel(64'(a8), 64'(b8), 8, sgn);
            if (r[2] && m_lt != 16'hFFFF) m_lt <= m_lt + 16'd1;
            if (r[1] && m_gt != 16'hFFFF) m_gt <= m_gt + 16'd1;
            if (r[0] && m_eq != 16'hFFFF) m_eq <= m_eq + 16'd1;
        end
    end
`endif

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        chk("w1",  64'({o1_v, o1_lt, o1_gt, o1_eq}),     64'(m1));
        chk("w8",  64'({o8_v, o8_lt, o8_gt, o8_eq}),     64'(m8));
        chk("w13", 64'({o13_v, o13_lt, o13_gt, o13_eq}), 64'(m13));
        if (o8_v)  chk("onehot8",  64'(o8_lt + o8_gt + o8_eq),    64'd1);
        if (o13_v) chk("onehot13", 64'(o13_lt + o13_gt + o13_eq), 64'd1);
`ifdef COMPARATOR_STATS_EN
        chk("cnt8", {16'h0, c8_lt, c8_gt, c8_eq}, {16'h0, m_lt, m_gt, m_eq});
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv8(input logic v, input logic s, input logic [7:0] a, input logic [7:0] b);
        valid = v; sgn = s; a8 = a; b8 = b;
        cyc();
    endtask

    logic [0:0] t1a [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [0:0] t1b [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] t1e [4] = '{4'b1001, 4'b1100, 4'b1010, 4'b1001};

    initial begin
        #3;
        chk("rst_init", 64'({o1_v, o8_v, o8_lt, o8_gt, o8_eq, o13_v}), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // WIDTH=1 unsigned exhaustive.
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; sgn = 1'b0; a1 = t1a[i]; b1 = t1b[i];
            cyc();
            chk("w1_tab", 64'({o1_v, o1_lt, o1_gt, o1_eq}), 64'(t1e[i]));
        end
        // WIDTH=1 signed: 1 is -1.
        sgn = 1'b1; a1 = 1'b1; b1 = 1'b0;
        cyc();
        chk("w1_sgn", 64'({o1_v, o1_lt, o1_gt, o1_eq}), 64'b1100);

        // -128 vs 127 signed and unsigned.
        drv8(1'b1, 1'b1, 8'h80, 8'h7F);
        chk("s80_7f", 64'({o8_v, o8_lt, o8_gt, o8_eq}), 64'b1100);
        drv8(1'b1, 1'b0, 8'h80, 8'h7F);
        chk("u80_7f", 64'({o8_v, o8_lt, o8_gt, o8_eq}), 64'b1010);

        // Single pulse, result held over idle cycles.
        drv8(1'b1, 1'b0, 8'd5, 8'd5);
        chk("eq_pulse", 64'({o8_v, o8_lt, o8_gt, o8_eq}), 64'b1001);
        for (int i = 0; i < 3; i++) begin
            drv8(1'b0, 1'b0, 8'd7, 8'd1);
            chk("eq_hold", 64'({o8_v, o8_lt, o8_gt, o8_eq}), 64'b0001);
        end

        // Back-to-back.
        drv8(1'b1, 1'b0, 8'd3, 8'd9);
        chk("b2b_lt", 64'({o8_v, o8_lt, o8_gt, o8_eq}), 64'b1100);
        drv8(1'b1, 1'b0, 8'd9, 8'd3);
        chk("b2b_gt", 64'({o8_v, o8_lt, o8_gt, o8_eq}), 64'b1010);

        // Asynchronous reset mid-cycle, no edge needed.
        #1 rst_n = 1'b0;
        #1 chk("rst_async", 64'({o1_v, o1_lt, o1_gt, o1_eq, o8_v, o8_lt, o8_gt, o8_eq,
                                 o13_v, o13_lt, o13_gt, o13_eq}), 64'd0);
        valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_rel", 64'({o8_v, o8_lt, o8_gt, o8_eq}), 64'd0);

        // Random run.
        for (int n = 0; n < 1000; n++) begin
            valid = ($urandom_range(0, 3) != 0);
            sgn   = 1'($urandom);
            a1  = 1'($urandom);  b1  = ($urandom_range(0, 3) == 0) ? a1  : 1'($urandom);
            a8  = 8'($urandom);  b8  = ($urandom_range(0, 3) == 0) ? a8  : 8'($urandom);
            a13 = 13'($urandom); b13 = ($urandom_range(0, 3) == 0) ? a13 : 13'($urandom);
`ifdef COMPARATOR_STATS_EN
            clr = ($urandom_range(0, 31) == 0);
`endif
            cyc();
        end

`ifdef COMPARATOR_STATS_EN
        valid = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) drv8(1'b1, 1'b0, 8'(i * 40), 8'(i * 40));
        for (int i = 0; i < 2; i++) drv8(1'b1, 1'b1, 8'hF0, 8'h05);
        drv8(1'b0, 1'b0, 8'd0, 8'd0);
        chk("st_eq", 64'(c8_eq), 64'd3);
        chk("st_lt", 64'(c8_lt), 64'd2);
        chk("st_gt", 64'(c8_gt), 64'd0);
        clr = 1'b1;
        drv8(1'b1, 1'b0, 8'd1, 8'd2);
        clr = 1'b0;
        chk("st_clr", 64'({c8_lt, c8_gt, c8_eq}), 64'd0);
`endif

        valid = 1'b0;
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
